// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch-state encoding, reset constants
// and small PC helpers used by the fetch stage.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

    // Sequential fetch address; wraps naturally at the top of the address space.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Branch targets are forced onto a word boundary before use.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks a fetched instruction while decode is stalled.
module fetch_hold_buf
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    // Clear wins over load so a redirect always empties the buffer.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = load_pc;
            instr_d = load_instr;
        end
    end

    // Buffer storage with asynchronous reset to an empty entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= NOP_INSTR_C;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/if_id_fetch.sv
// Instruction fetch stage and IF/ID pipeline register. Keeps at most one
// memory request in flight, buffers a response that arrives under stall and
// discards responses made stale by a redirect.
module if_id_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_C,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [6:0]  if_id_opcode
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         drop_q, drop_d;
    logic         if_id_valid_q, if_id_valid_d;
    logic [31:0]  if_id_pc_q, if_id_pc_d;
    logic [31:0]  if_id_instr_q, if_id_instr_d;

    logic         hold_load, hold_clear;
    logic         hold_valid;
    logic [31:0]  hold_pc, hold_instr;
    logic         accept;
    logic         deliver;
    logic [31:0]  deliver_pc, deliver_instr;

    assign imem_req  = (state_q == FETCH_REQ);
    assign imem_addr = pc_q;
    assign accept    = imem_req & imem_ready;

    fetch_hold_buf u_hold (
        .clk        (clk),
        .rst        (rst),
        .load       (hold_load),
        .clear      (hold_clear),
        .load_pc    (fetch_pc_q),
        .load_instr (imem_rdata),
        .valid      (hold_valid),
        .pc         (hold_pc),
        .instr      (hold_instr)
    );

    // Next-state, PC and IF/ID update; a redirect overrides every other event.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_pc_d    = fetch_pc_q;
        drop_d        = drop_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        hold_load     = 1'b0;
        hold_clear    = 1'b0;
        deliver       = 1'b0;
        deliver_pc    = if_id_pc_q;
        deliver_instr = imem_rdata;

        if (redirect) begin
            pc_d          = word_align(redirect_pc);
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
            hold_clear    = 1'b1;
            case (state_q)
                FETCH_REQ: begin
                    if (accept) begin
                        drop_d  = 1'b1;
                        state_d = FETCH_WAIT;
                    end else begin
                        state_d = FETCH_REQ;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = FETCH_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = FETCH_WAIT;
                    end
                end
                default: begin
                    drop_d  = 1'b0;
                    state_d = FETCH_REQ;
                end
            endcase
        end else begin
            case (state_q)
                FETCH_REQ: begin
                    if (accept) begin
                        fetch_pc_d = pc_q;
                        pc_d       = pc_plus4(pc_q);
                        state_d    = FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = FETCH_REQ;
                        end else if (stall) begin
                            hold_load = 1'b1;
                            state_d   = FETCH_HOLD;
                        end else begin
                            deliver       = 1'b1;
                            deliver_pc    = fetch_pc_q;
                            deliver_instr = imem_rdata;
                            state_d       = FETCH_REQ;
                        end
                    end
                end
                FETCH_HOLD: begin
                    if (!stall) begin
                        deliver       = hold_valid;
                        deliver_pc    = hold_pc;
                        deliver_instr = hold_instr;
                        hold_clear    = 1'b1;
                        state_d       = FETCH_REQ;
                    end
                end
                default: begin
                    state_d = FETCH_REQ;
                end
            endcase

            if (!stall) begin
                if (deliver) begin
                    if_id_valid_d = 1'b1;
                    if_id_pc_d    = deliver_pc;
                    if_id_instr_d = deliver_instr;
                end else begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                end
            end
        end
    end

    // Fetch-control and IF/ID registers; reset abandons any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH_REQ;
            pc_q          <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            drop_q        <= 1'b0;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= RESET_PC;
            if_id_instr_q <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_pc_q    <= fetch_pc_d;
            drop_q        <= drop_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
        end
    end

    assign if_id_valid  = if_id_valid_q;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_instr  = if_id_instr_q;
    assign if_id_opcode = if_id_instr_q[6:0];

endmodule

// File: tb/tb_if_id_fetch.sv
// Self-checking bench for the fetch stage: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_if_id_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [6:0]  if_id_opcode;

    int nChecks = 0;
    int nErrors = 0;

    // Model: architectural PC, the one outstanding request, the parked word
    // and the IF/ID contents.
    logic [31:0] mPc;
    logic        mBusy;
    logic        mDrop;
    logic [31:0] mFetchPc;
    logic        mHeld;
    logic [31:0] mHeldPc, mHeldInstr;
    logic        mValid;
    logic [31:0] mIfPc, mIfInstr;
    int          memCnt;

    if_id_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_opcode (if_id_opcode)
    );

    always #5 clk = ~clk;

    function automatic logic expReq();
        return !mBusy && !mHeld;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPc = 32'h0; mBusy = 0; mDrop = 0; mFetchPc = 32'h0;
        mHeld = 0; mHeldPc = 32'h0; mHeldInstr = 32'h0;
        mValid = 0; mIfPc = 32'h0; mIfInstr = NOP; memCnt = 0;
    endtask

    // Advances the model by one clock edge using the inputs applied this cycle.
    task automatic modelUpdate();
        logic acc, resp, got;
        logic [31:0] gPc, gInstr;
        acc  = expReq() && imem_ready;
        resp = mBusy && imem_rvalid;
        got  = 0; gPc = 0; gInstr = 0;
        if (acc) memCnt = $urandom_range(1, 3);
        if (redirect) begin
            mPc = redirect_pc & 32'hFFFF_FFFC;
            mValid = 0; mIfInstr = NOP;
            mHeld = 0;
            if (acc) begin mBusy = 1; mDrop = 1; end
            else if (resp) begin mBusy = 0; mDrop = 0; end
            else if (mBusy) mDrop = 1;
        end else begin
            if (resp) begin
                mBusy = 0;
                if (mDrop) mDrop = 0;
                else if (stall) begin mHeld = 1; mHeldPc = mFetchPc; mHeldInstr = imem_rdata; end
                else begin got = 1; gPc = mFetchPc; gInstr = imem_rdata; end
            end else if (mHeld && !stall) begin
                got = 1; gPc = mHeldPc; gInstr = mHeldInstr; mHeld = 0;
            end
            if (acc) begin mBusy = 1; mFetchPc = mPc; mPc = mPc + 32'd4; end
            if (!stall) begin
                if (got) begin mValid = 1; mIfPc = gPc; mIfInstr = gInstr; end
                else begin mValid = 0; mIfInstr = NOP; end
            end
        end
    endtask

    task automatic checkOutput();
        cmp("imem_req", {31'b0, imem_req}, {31'b0, expReq()});
        cmp("imem_addr", imem_addr, mPc);
        cmp("if_id_valid", {31'b0, if_id_valid}, {31'b0, mValid});
        cmp("if_id_pc", if_id_pc, mIfPc);
        cmp("if_id_instr", if_id_instr, mIfInstr);
        cmp("if_id_opcode", {25'b0, if_id_opcode}, {25'b0, mIfInstr[6:0]});
    endtask

    // One clock: drive inputs, let the edge happen, compare on the falling edge.
    task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rd,
                                 input logic st, input logic redir, input logic [31:0] rpc);
        imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
        stall = st; redirect = redir; redirect_pc = rpc;
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        logic rdy, rv, st, redir;
        logic [31:0] rpc;
        rst = 1; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
        stall = 0; redirect = 0; redirect_pc = 0;
        modelReset();
        repeat (2) @(negedge clk);
        cmp("rst_valid", {31'b0, if_id_valid}, 32'd0);
        cmp("rst_pc", if_id_pc, 32'h0);
        cmp("rst_instr", if_id_instr, NOP);
        rst = 0;
        #1 cmp("post_rst_req", {31'b0, imem_req}, 32'd1);

        // Two back-to-back fetches with single-cycle latency.
        applyStimulus(1, 0, 0, 0, 0, 0);
        cmp("accept_addr", imem_addr, 32'h4);
        applyStimulus(0, 1, 32'h0f200700, 0, 0, 0);
        cmp("w0_valid", {31'b0, if_id_valid}, 32'd1);
        cmp("w0_pc", if_id_pc, 32'h0);
        cmp("w0_opcode", {25'b0, if_id_opcode}, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'hff200000, 0, 0, 0);
        cmp("w1_valid", {31'b0, if_id_valid}, 32'd1);
        cmp("w1_pc", if_id_pc, 32'h4);
        cmp("w1_opcode", {25'b0, if_id_opcode}, 32'h0);

        // Response arrives under a three-cycle stall and is parked.
        applyStimulus(1, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 32'h1234_5673, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        cmp("stall_pc", if_id_pc, 32'h4);
        cmp("stall_instr", if_id_instr, 32'hff200000);
        cmp("stall_req", {31'b0, imem_req}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        cmp("release_valid", {31'b0, if_id_valid}, 32'd1);
        cmp("release_pc", if_id_pc, 32'h8);
        cmp("release_instr", if_id_instr, 32'h1234_5673);

        // Redirect while waiting: stale word dropped, fetch resumes at target.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h0000_0103);
        cmp("redir_addr", imem_addr, 32'h100);
        applyStimulus(0, 1, 32'hdead_beef, 0, 0, 0);
        cmp("stale_valid", {31'b0, if_id_valid}, 32'd0);
        cmp("stale_req", {31'b0, imem_req}, 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h0000_0533, 0, 0, 0);
        cmp("redir_word_pc", if_id_pc, 32'h100);
        cmp("redir_word_valid", {31'b0, if_id_valid}, 32'd1);

        // Redirect and stall together still flush IF/ID.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h0000_0633, 1, 1, 32'h0000_0200);
        cmp("flush_valid", {31'b0, if_id_valid}, 32'd0);
        cmp("flush_instr", if_id_instr, NOP);
        cmp("flush_addr", imem_addr, 32'h200);

        // PC wraps from the last word to zero.
        applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        applyStimulus(1, 0, 0, 0, 0, 0);
        cmp("wrap_addr", imem_addr, 32'h0);
        applyStimulus(0, 1, 32'h0000_0733, 0, 0, 0);
        cmp("wrap_pc", if_id_pc, 32'hFFFF_FFFC);

        // Asynchronous reset in the middle of an outstanding request.
        applyStimulus(1, 0, 0, 0, 0, 0);
        imem_ready = 0;
        #2 rst = 1;
        #1;
        cmp("async_valid", {31'b0, if_id_valid}, 32'd0);
        cmp("async_pc", if_id_pc, 32'h0);
        cmp("async_instr", if_id_instr, NOP);
        cmp("async_addr", imem_addr, 32'h0);
        modelReset();
        @(negedge clk);
        rst = 0;
        #1 cmp("async_release_req", {31'b0, imem_req}, 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            st    = ($urandom_range(0, 9) < 3);
            redir = ($urandom_range(0, 15) == 0);
            rpc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            rdy   = ($urandom_range(0, 9) < 6);
            rv    = 0;
            if (mBusy) begin
                if (memCnt <= 1) rv = 1;
                else memCnt--;
            end
            applyStimulus(rdy, rv, $urandom, st, redir, rpc);
        end

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/if_id_fetch.md
IF_ID_FETCH -- requirements
Module: if_id_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, SHALL be the instruction presented on flush or bubble.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 imem_req  output  1  SHALL request an instruction-memory fetch.
REQ-006 imem_addr  output  32  SHALL be the fetch address, equal to the current PC.
REQ-007 imem_ready  input  1  SHALL mean the request is accepted this cycle.
REQ-008 imem_rvalid  input  1  SHALL mean imem_rdata is valid this cycle.
REQ-009 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-010 stall  input  1  SHALL be the hazard-unit stall: IF/ID holds its contents.
REQ-011 redirect  input  1  SHALL be the taken branch/jump signal from EX: flush and jump.
REQ-012 redirect_pc  input  32  SHALL be the redirect target.
REQ-013 if_id_valid  output  1  SHALL mean the IF/ID register holds a real instruction.
REQ-014 if_id_pc  output  32  SHALL be the PC of if_id_instr.
REQ-015 if_id_instr  output  32  SHALL be the registered instruction feeding decode/immediate generation.
REQ-016 if_id_opcode  output  7  SHALL equal if_id_instr[6:0] (combinational from register).

Function
REQ-017 FSM SHALL have states REQ (issue fetch), WAIT (one request outstanding) and HOLD (response buffered under stall); at most one request SHALL be outstanding.
REQ-018 In REQ, imem_req=1; on imem_ready=1 the FSM SHALL go to WAIT and PC SHALL become PC+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-019 imem_req SHALL be 0 in WAIT and HOLD.
REQ-020 Minimum memory latency SHALL be 1 cycle: request accepted in cycle N, rvalid in cycle N+k (k>=1), IF/ID updated at the edge ending cycle N+k.
REQ-021 In WAIT with rvalid and stall=0, IF/ID SHALL load {valid=1, pc=fetched PC, instr=imem_rdata}; next state REQ.
REQ-022 In WAIT with rvalid and stall=1, the response SHALL go to the hold buffer and IF/ID SHALL be unchanged; next state HOLD.
REQ-023 In HOLD with stall=0, the hold buffer SHALL move into IF/ID; next state REQ. With stall=1 the FSM SHALL remain in HOLD.
REQ-024 With stall=0 and no instruction delivered this cycle, IF/ID SHALL load a bubble: valid=0, instr=NOP_INSTR, pc unchanged.
REQ-025 redirect SHALL take priority over stall and all other events. It SHALL set PC to {redirect_pc[31:2],2'b00}, flush IF/ID to a bubble, and clear the hold buffer.
REQ-026 On redirect in WAIT without a same-cycle rvalid, a drop flag SHALL be set. The next response SHALL be discarded and the FSM SHALL go to REQ.
REQ-027 On redirect with a same-cycle rvalid, that response SHALL be discarded. Next state SHALL be REQ.
REQ-028 On redirect in REQ with imem_ready=1, the accepted request SHALL be marked dropped; the next fetch SHALL use the redirected PC.
REQ-029 A discarded response SHALL never set if_id_valid.

Reset
REQ-030 Asserting rst SHALL immediately force: PC=RESET_PC, state=REQ, drop flag=0, hold buffer empty, if_id_valid=0, if_id_pc=RESET_PC, if_id_instr=NOP_INSTR.
REQ-031 Reset while a request is outstanding SHALL abandon it; the memory SHALL not return a response after reset.
REQ-032 imem_req SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-033 NOP_INSTR, the RESET_PC default and the fetch-state enum (REQ/WAIT/HOLD) SHALL live in the shared package riscv_pkg.
REQ-034 The hold buffer (valid, pc, instr) SHALL be a sub-module fetch_hold_buf; PC, FSM and IF/ID register SHALL stay in if_id_fetch.

Verification
REQ-035 Reset, then imem_ready=1 and 1-cycle latency returning 32'h0f200700 and 32'hff200000 -> if_id_pc 0 then 4, if_id_opcode 7'h00, if_id_valid=1 each.
REQ-036 stall=1 held 3 cycles while a response arrives -> IF/ID unchanged, FSM in HOLD, no imem_req; after release, buffered word appears in IF/ID one cycle later.
REQ-037 redirect to 32'h0000_0103 while WAIT -> next imem_addr=32'h0000_0100, stale response discarded, if_id_valid=0 until the new word arrives.
REQ-038 redirect and stall asserted together -> IF/ID flushed (valid=0, instr=32'h0000_0013) despite stall.
REQ-039 PC at 32'hFFFF_FFFC, fetch accepted -> next imem_addr=32'h0000_0000.
REQ-040 rst asserted mid-WAIT -> outputs reach reset values without a clock edge, and imem_req=1 in the first cycle after release.
